mmio_dispatch: RTL and testbench

MMIO_DISPATCH -- requirements
Module: mmio_dispatch

---
 rtl/mmio_dispatch.sv | 187 ++++++++++++++++++
 tb/tb_mmio_dispatch.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_dispatch.sv
// MMIO command dispatcher: routes one command at a time to an APB master or a memory port.
// Optional access timeout is built when MMIO_DISPATCH_TIMEOUT_EN is defined.
module mmio_dispatch #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_vld_i,
    output logic        cmd_ack_o,
    input  logic        cmd_dir_i,
    input  logic        cmd_apb_i,
    input  logic [3:0]  cmd_tag_i,
    input  logic [15:0] cmd_len_i,
    input  logic [27:0] cmd_adr_i,
    output logic        mmio_busy_o,
    output logic        mmio_done_o,
    output logic        apb_psel_o,
    output logic        apb_penable_o,
    output logic        apb_pwrite_o,
    output logic [27:0] apb_paddr_o,
    output logic [15:0] apb_pwdata_o,
    input  logic [15:0] apb_prdata_i,
    input  logic        apb_pready_i,
    input  logic        apb_pslverr_i,
    output logic        mem_req_o,
    input  logic        mem_ack_i,
    output logic        mem_dir_o,
    output logic [27:0] mem_adr_o,
    output logic [15:0] mem_len_o,
    input  logic        mem_done_i,
    input  logic        mem_err_i,
    output logic        rsp_vld_o,
    input  logic        rsp_rdy_i,
    output logic [3:0]  rsp_tag_o,
    output logic [1:0]  rsp_sts_o,
    output logic [15:0] rsp_dat_o
);

    if (TIMEOUT < 2) begin : g_timeout_check
        $error("mmio_dispatch: TIMEOUT must be at least 2");
    end

    typedef enum logic [5:0] {
        IDLE       = 6'b000001,
        APB_SETUP  = 6'b000010,
        APB_ACCESS = 6'b000100,
        MEM_REQ    = 6'b001000,
        MEM_WAIT   = 6'b010000,
        RESP       = 6'b100000
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_ack;
    logic        w_cap;
    logic [1:0]  w_sts;
    logic [15:0] w_dat;
    logic        w_bus;
    logic        w_tmo;

    logic        r_dir;
    logic        r_apb;
    logic [3:0]  r_tag;
    logic [15:0] r_len;
    logic [27:0] r_adr;
    logic [1:0]  r_sts;
    logic [15:0] r_dat;

    assign w_bus = (r_state == APB_SETUP) || (r_state == APB_ACCESS) ||
                   (r_state == MEM_REQ)   || (r_state == MEM_WAIT);

`ifdef MMIO_DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] r_tmo;

    // Counter sits at zero outside bus states, so it is clear on every bus entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_tmo <= '0;
        else if (w_bus)
            r_tmo <= r_tmo + 1'b1;
        else
            r_tmo <= '0;
    end

    assign w_tmo = w_bus && (r_tmo == TMO_LAST);
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        w_ack  = 1'b0;
        w_cap  = 1'b0;
        w_sts  = 2'd0;
        w_dat  = 16'd0;
        case (r_state)
            IDLE: begin
                if (cmd_vld_i) begin
                    w_ack  = 1'b1;
                    w_next = cmd_apb_i ? APB_SETUP : MEM_REQ;
                end
            end
            APB_SETUP:  w_next = APB_ACCESS;
            APB_ACCESS: begin
                if (apb_pready_i) begin
                    w_cap  = 1'b1;
                    w_sts  = {1'b0, apb_pslverr_i};
                    w_dat  = (r_apb && r_dir) ? apb_prdata_i : 16'd0;
                    w_next = RESP;
                end
            end
            MEM_REQ: begin
                if (mem_ack_i)
                    w_next = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (mem_done_i) begin
                    w_cap  = 1'b1;
                    w_sts  = {1'b0, mem_err_i};
                    w_next = RESP;
                end
            end
            RESP: begin
                if (rsp_rdy_i)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // A completion in the same cycle as the timeout wins.
        if (w_tmo && !w_cap) begin
            w_cap  = 1'b1;
            w_sts  = 2'd2;
            w_dat  = 16'd0;
            w_next = RESP;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_dir   <= 1'b0;
            r_apb   <= 1'b0;
            r_tag   <= 4'd0;
            r_len   <= 16'd0;
            r_adr   <= 28'd0;
            r_sts   <= 2'd0;
            r_dat   <= 16'd0;
        end else begin
            r_state <= w_next;
            if (w_ack) begin
                r_dir <= cmd_dir_i;
                r_apb <= cmd_apb_i;
                r_tag <= cmd_tag_i;
                r_len <= cmd_len_i;
                r_adr <= cmd_adr_i;
            end
            if (w_cap) begin
                r_sts <= w_sts;
                r_dat <= w_dat;
            end
        end
    end

    // Ack is gated by reset so it is low for the whole reset interval.
    assign cmd_ack_o     = w_ack && !reset;
    assign mmio_busy_o   = (r_state != IDLE);
    assign mmio_done_o   = (r_state == RESP) && rsp_rdy_i;

    assign apb_psel_o    = (r_state == APB_SETUP) || (r_state == APB_ACCESS);
    assign apb_penable_o = (r_state == APB_ACCESS);
    assign apb_pwrite_o  = !r_dir;
    assign apb_paddr_o   = r_adr;
    assign apb_pwdata_o  = r_len;

    assign mem_req_o     = (r_state == MEM_REQ);
    assign mem_dir_o     = r_dir;
    assign mem_adr_o     = r_adr;
    assign mem_len_o     = r_len;

    assign rsp_vld_o     = (r_state == RESP);
    assign rsp_tag_o     = r_tag;
    assign rsp_sts_o     = r_sts;
    assign rsp_dat_o     = r_dat;

endmodule

// File: tb/tb_mmio_dispatch.sv
// Self-checking bench for mmio_dispatch: directed scenarios plus randomized commands
// checked cycle by cycle against a transaction-timeline reference model.
module tb_mmio_dispatch;

    localparam int TMO = 16;
`ifdef MMIO_DISPATCH_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_vld_i, cmd_ack_o, cmd_dir_i, cmd_apb_i;
    logic [3:0]  cmd_tag_i;
    logic [15:0] cmd_len_i;
    logic [27:0] cmd_adr_i;
    logic        mmio_busy_o, mmio_done_o;
    logic        apb_psel_o, apb_penable_o, apb_pwrite_o;
    logic [27:0] apb_paddr_o;
    logic [15:0] apb_pwdata_o, apb_prdata_i;
    logic        apb_pready_i, apb_pslverr_i;
    logic        mem_req_o, mem_ack_i, mem_dir_o;
    logic [27:0] mem_adr_o;
    logic [15:0] mem_len_o;
    logic        mem_done_i, mem_err_i;
    logic        rsp_vld_o, rsp_rdy_i;
    logic [3:0]  rsp_tag_o;
    logic [1:0]  rsp_sts_o;
    logic [15:0] rsp_dat_o;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    mmio_dispatch #(.TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .cmd_vld_i(cmd_vld_i), .cmd_ack_o(cmd_ack_o), .cmd_dir_i(cmd_dir_i),
        .cmd_apb_i(cmd_apb_i), .cmd_tag_i(cmd_tag_i), .cmd_len_i(cmd_len_i),
        .cmd_adr_i(cmd_adr_i), .mmio_busy_o(mmio_busy_o), .mmio_done_o(mmio_done_o),
        .apb_psel_o(apb_psel_o), .apb_penable_o(apb_penable_o), .apb_pwrite_o(apb_pwrite_o),
        .apb_paddr_o(apb_paddr_o), .apb_pwdata_o(apb_pwdata_o), .apb_prdata_i(apb_prdata_i),
        .apb_pready_i(apb_pready_i), .apb_pslverr_i(apb_pslverr_i),
        .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i), .mem_dir_o(mem_dir_o),
        .mem_adr_o(mem_adr_o), .mem_len_o(mem_len_o), .mem_done_i(mem_done_i),
        .mem_err_i(mem_err_i), .rsp_vld_o(rsp_vld_o), .rsp_rdy_i(rsp_rdy_i),
        .rsp_tag_o(rsp_tag_o), .rsp_sts_o(rsp_sts_o), .rsp_dat_o(rsp_dat_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ctl();
        return {mmio_busy_o, cmd_ack_o, apb_psel_o, apb_penable_o, mem_req_o, rsp_vld_o, mmio_done_o};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One command from acceptance to response handshake.
    // APB: w1 = wait cycles before pready. Memory: w1 = cycles before mem_ack, w2 = cycles
    // in MEM_WAIT before mem_done. rd = cycles rsp_rdy is held low in RESP.
    // early = also pulse mem_done together with mem_ack (must be ignored).
    task automatic run_txn(input bit dir, input bit apb, input logic [3:0] tag,
                           input logic [15:0] len, input logic [27:0] adr,
                           input int w1, input int w2, input bit err,
                           input logic [15:0] rdat, input int rd,
                           input bit early, input bit vld_busy);
        int         bus_n, resp_k, cmp_k, ack_k;
        bit         tmo;
        logic [1:0] e_sts;
        logic [15:0] e_dat;
        logic [6:0] e_ctl;
        bus_n  = apb ? 2 + w1 : 2 + w1 + w2;
        tmo    = TMO_EN && (bus_n > TMO);
        resp_k = tmo ? TMO + 1 : bus_n + 1;
        cmp_k  = bus_n;
        ack_k  = 1 + w1;
        e_sts  = tmo ? 2'd2 : {1'b0, err};
        e_dat  = (!tmo && apb && dir) ? rdat : 16'd0;

        cmd_dir_i = dir; cmd_apb_i = apb; cmd_tag_i = tag;
        cmd_len_i = len; cmd_adr_i = adr; cmd_vld_i = 1'b1;
        @(negedge clock);
        chk("accept", {mmio_busy_o, cmd_ack_o, rsp_vld_o}, 3'b010);
        step();
        for (int k = 1; k <= resp_k + rd; k++) begin
            cmd_vld_i = vld_busy ? 1'b1 : 1'($urandom_range(0, 1));
            cmd_dir_i = 1'($urandom); cmd_apb_i = 1'($urandom);
            cmd_tag_i = 4'($urandom); cmd_len_i = 16'($urandom); cmd_adr_i = 28'($urandom);
            apb_pready_i  = apb ? (k == cmp_k) : 1'($urandom);
            apb_prdata_i  = (apb && k == cmp_k) ? rdat : 16'($urandom);
            apb_pslverr_i = (apb && k == cmp_k) ? err : 1'($urandom);
            mem_ack_i     = apb ? 1'($urandom) : (k == ack_k);
            mem_done_i    = apb ? 1'($urandom) : ((k == cmp_k) || (early && k == ack_k));
            mem_err_i     = (!apb && k == cmp_k) ? err : !err;
            rsp_rdy_i     = (k >= resp_k) ? (k == resp_k + rd) : 1'($urandom);

            if (k >= resp_k)
                e_ctl = {1'b1, 1'b0, 3'b000, 1'b1, (k == resp_k + rd)};
            else if (apb)
                e_ctl = {1'b1, 1'b0, 1'b1, (k != 1), 3'b000};
            else
                e_ctl = {1'b1, 1'b0, 2'b00, (k <= ack_k), 2'b00};

            @(negedge clock);
            chk("ctl", ctl(), e_ctl);
            if (apb && k == 1)
                chk("apb_setup", {apb_pwrite_o, apb_paddr_o, apb_pwdata_o}, {!dir, adr, len});
            if (!apb && k < resp_k && k <= ack_k)
                chk("mem_cmd", {mem_dir_o, mem_adr_o, mem_len_o}, {dir, adr, len});
            if (k >= resp_k)
                chk("rsp", {rsp_tag_o, rsp_sts_o, rsp_dat_o}, {tag, e_sts, e_dat});
            step();
        end
        cmd_vld_i = 1'b0; rsp_rdy_i = 1'b0; apb_pready_i = 1'b0;
        mem_ack_i = 1'b0; mem_done_i = 1'b0; apb_pslverr_i = 1'b0; mem_err_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cmd_vld_i = 1'b1; cmd_dir_i = 1'b0; cmd_apb_i = 1'b1;
        cmd_tag_i = 4'hA; cmd_len_i = 16'h55AA; cmd_adr_i = 28'h123;
        apb_prdata_i = 16'd0; apb_pready_i = 1'b0; apb_pslverr_i = 1'b0;
        mem_ack_i = 1'b0; mem_done_i = 1'b0; mem_err_i = 1'b0; rsp_rdy_i = 1'b0;

        // Reset state, with a pending command that must not be acknowledged.
        step(); step();
        @(negedge clock);
        chk("rst_ctl", ctl(), 7'd0);
        chk("rst_rsp", {rsp_tag_o, rsp_sts_o, rsp_dat_o}, 22'd0);
        step();
        cmd_vld_i = 1'b0;
        reset = 1'b0;
        step();
        @(negedge clock);
        chk("idle_ctl", ctl(), 7'd0);
        step();

        // APB write, pready on first access cycle; rsp_vld in the 4th cycle counting the ack cycle.
        run_txn(1'b0, 1'b1, 4'd5, 16'hBEEF, 28'h0000010, 0, 0, 1'b0, 16'h0, 0, 1'b0, 1'b0);
        // APB read, three wait cycles.
        run_txn(1'b1, 1'b1, 4'd9, 16'h0000, 28'h0000020, 3, 0, 1'b0, 16'h1234, 1, 1'b0, 1'b0);
        // Memory read with error, early done alongside ack is ignored.
        run_txn(1'b1, 1'b0, 4'd3, 16'd512, 28'h0ABCDEF, 2, 1, 1'b1, 16'h0, 0, 1'b1, 1'b0);
        // Back-to-back: command held valid through a stalled response.
        run_txn(1'b0, 1'b1, 4'd7, 16'h0F0F, 28'h0000040, 1, 0, 1'b1, 16'h0, 5, 1'b0, 1'b1);
        run_txn(1'b0, 1'b0, 4'd8, 16'h0100, 28'h0000080, 0, 0, 1'b0, 16'h0, 0, 1'b0, 1'b0);
        // pready stuck low: times out when the counter is built, otherwise psel holds throughout.
        run_txn(1'b1, 1'b1, 4'd11, 16'h0000, 28'h0000100, 30, 0, 1'b0, 16'hCAFE, 0, 1'b0, 1'b0);
        run_txn(1'b0, 1'b0, 4'd12, 16'h0040, 28'h0000200, 20, 0, 1'b0, 16'h0, 1, 1'b0, 1'b0);
        // Completion on the very last allowed cycle still counts as a normal completion.
        run_txn(1'b1, 1'b1, 4'd13, 16'h0000, 28'h0000300, TMO - 2, 0, 1'b0, 16'h7777, 0, 1'b0, 1'b0);

        // Reset in the middle of an APB access.
        run_txn(1'b1, 1'b1, 4'd14, 16'h0000, 28'h0000400, 0, 0, 1'b1, 16'h9999, 0, 1'b0, 1'b0);
        cmd_dir_i = 1'b1; cmd_apb_i = 1'b1; cmd_tag_i = 4'd6;
        cmd_len_i = 16'h0; cmd_adr_i = 28'h500; cmd_vld_i = 1'b1;
        step();
        cmd_vld_i = 1'b0;
        step();
        @(negedge clock);
        chk("pre_rst_access", ctl(), 7'b1011000);
        #2;
        reset = 1'b1;
        apb_pready_i = 1'b1;
        apb_prdata_i = 16'hDEAD;
        #1;
        chk("rst_async_ctl", ctl(), 7'd0);
        chk("rst_async_rsp", {rsp_tag_o, rsp_sts_o, rsp_dat_o}, 22'd0);
        step();
        reset = 1'b0;
        apb_pready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("post_rst_idle", ctl(), 7'd0);
            step();
        end
        run_txn(1'b1, 1'b1, 4'd6, 16'h0000, 28'h0000500, 1, 0, 1'b0, 16'h4321, 0, 1'b0, 1'b0);

        // Randomized commands, kept short enough that the timeout never fires.
        for (int t = 0; t < 24; t++) begin
            run_txn(1'($urandom), 1'($urandom), 4'($urandom), 16'($urandom), 28'($urandom),
                    $urandom_range(0, 8), $urandom_range(0, 5), 1'($urandom), 16'($urandom),
                    $urandom_range(0, 3), 1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
